// File: rtl/serial_subtractor.sv
// Bit-serial a-b / b-a subtractor producing diff, |a-b|, a<b and a==b.
// Latency: out_valid rises WIDTH edges after the input handshake; one operation in flight.
// Backpressure: DONE and all outputs hold until out_ready; in_ready is low outside IDLE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] abs_diff,
  output logic             a_lt_b,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, r_ab, r_ba;
  logic             br_ab, br_ba;
  logic [CW-1:0]    cnt;

  logic             ai, bi, d_ab, d_ba, nbr_ab, nbr_ba;
  logic [WIDTH-1:0] nr_ab, nr_ba;

  // Both directions run in parallel so |a-b| is ready without a second pass.
  always_comb begin
    ai     = sa[0];
    bi     = sb[0];
    d_ab   = ai ^ bi ^ br_ab;
    d_ba   = ai ^ bi ^ br_ba;
    nbr_ab = (~ai & bi) | (~(ai ^ bi) & br_ab);
    nbr_ba = (~bi & ai) | (~(ai ^ bi) & br_ba);
    nr_ab  = {d_ab, r_ab[WIDTH-1:1]};
    nr_ba  = {d_ba, r_ba[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      r_ab     <= '0;
      r_ba     <= '0;
      br_ab    <= 1'b0;
      br_ba    <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      abs_diff <= '0;
      a_lt_b   <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            r_ab  <= '0;
            r_ba  <= '0;
            br_ab <= 1'b0;
            br_ba <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          r_ab  <= nr_ab;
          r_ba  <= nr_ba;
          br_ab <= nbr_ab;
          br_ba <= nbr_ba;
          cnt   <= cnt + CW'(1);
          // Final borrow out of a-b is exactly the unsigned a<b flag.
          if (cnt == LAST) begin
            state    <= DONE;
            diff     <= nr_ab;
            a_lt_b   <= nbr_ab;
            abs_diff <= nbr_ab ? nr_ba : nr_ab;
            zero     <= (nr_ab == '0);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed cases, backpressure,
// mid-operation reset and a handful of random operand pairs.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff, abs_diff;
  logic       a_lt_b, zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] diff;
    logic [7:0] abs_diff;
    logic       lt;
    logic       zero;
  } exp_t;

  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .abs_diff  (abs_diff),
    .a_lt_b    (a_lt_b),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.diff     = x - y;
    e.abs_diff = (x < y) ? (y - x) : (x - y);
    e.lt       = (x < y);
    e.zero     = (x == y);
    sb_q.push_back(e);
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input bit track);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    if (track) push_exp(x, y);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("diff",     32'(diff),     32'(e.diff));
      check("abs_diff", 32'(abs_diff), 32'(e.abs_diff));
      check("a_lt_b",   32'(a_lt_b),   32'(e.lt));
      check("zero",     32'(zero),     32'(e.zero));
    end
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y);
    int n;
    out_ready = 1'b1;
    start_op(x, y, 1'b1);
    wait_out(n);
    check("latency", 32'(n), 32'd8);
    check_out();
    @(negedge clk);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_abs",       32'(abs_diff),  32'd0);
    check("rst_lt",        32'(a_lt_b),    32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C);
    run_op(8'h03, 8'h10);
    run_op(8'h80, 8'h80);
    run_op(8'h00, 8'hFF);

    // Backpressure: hold DONE while offering new operands that must be ignored.
    out_ready = 1'b0;
    start_op(8'h5A, 8'h3C, 1'b1);
    wait_out(n);
    check("bp_latency", 32'(n), 32'd8);
    check_out();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a        = 8'h11;
      b        = 8'h22;
      in_valid = (i % 2 == 0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff",      32'(diff),      32'h1E);
      check("bp_abs",       32'(abs_diff),  32'h1E);
      check("bp_lt",        32'(a_lt_b),    32'd0);
      check("bp_zero",      32'(zero),      32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_hold_diff",     32'(diff),      32'h1E);
    run_op(8'h11, 8'h22);

    // Reset four cycles into SHIFT discards the operation immediately.
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff",      32'(diff),      32'd0);
    check("mid_rst_abs",       32'(abs_diff),  32'd0);
    check("mid_rst_lt",        32'(a_lt_b),    32'd0);
    check("mid_rst_zero",      32'(zero),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h40, 8'h01);

    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
